// File: rtl/shift_issue_queue.sv
// shift_issue_queue: command FIFO feeding a combinational barrel shifter with a registered result slot.
module shift_issue_queue #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [2:0] in_num,
   input  logic [1:0] in_ctl,
   output logic [7:0] shift_in,
   output logic [2:0] shift_num,
   output logic [1:0] shift_ctl,
   input  logic [7:0] shift_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_zero
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   logic [12:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          empty, push, pop;
   assign empty    = count == '0;
   assign in_ready = count != FULL_CNT;
   assign push     = in_valid && in_ready;
   assign pop      = !empty && (!out_valid || out_ready);
   // Head is read straight from storage so the shifter sees it in the same cycle.
   assign shift_in  = empty ? 8'h00 : mem[rd_ptr][12:5];
   assign shift_num = empty ? 3'h0 : mem[rd_ptr][4:2];
   assign shift_ctl = empty ? 2'h0 : mem[rd_ptr][1:0];
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_data, in_num, in_ctl};
   end
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_zero  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            out_data  <= shift_out;
            out_zero  <= shift_out == 8'h00;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      end
   end
endmodule

// File: tb/tb_shift_issue_queue.sv
// tb_shift_issue_queue: queue-level reference model checked every cycle plus directed literal vectors.
module tb_shift_issue_queue;
   localparam int DEPTH = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic [2:0] in_num = 3'h0;
   logic [1:0] in_ctl = 2'h0;
   logic       in_ready, out_valid, out_zero;
   logic [7:0] shift_in, shift_out, out_data;
   logic [2:0] shift_num;
   logic [1:0] shift_ctl;
   int checks = 0, failures = 0;

   shift_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_num(in_num), .in_ctl(in_ctl),
      .shift_in(shift_in), .shift_num(shift_num), .shift_ctl(shift_ctl),
      .shift_out(shift_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] n, input logic [1:0] c);
      logic [15:0] w;
      w = {8'h00, d};
      if (c == 2'b00) return 8'(w << n);
      if (c == 2'b01) return d >> n;
      if (c == 2'b10) return 8'($signed(d) >>> n);
      return 8'((w >> n) | (w << (4'd8 - {1'b0, n})));
   endfunction

   assign shift_out = shf(shift_in, shift_num, shift_ctl);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {logic [7:0] d; logic [2:0] n; logic [1:0] c;} cmd_t;
   cmd_t       m_q[$];
   logic       m_v = 1'b0, m_z = 1'b0, armed = 1'b0;
   logic [7:0] m_d = 8'h00;
   int         nacc = 0, dres = 0;

   always @(posedge clk) begin
      bit   push, pop;
      cmd_t h;
      if (out_valid === 1'b1 && out_ready) dres++;
      if (rst || flush) begin
         m_q.delete();
         m_v = 1'b0;
         m_d = 8'h00;
         m_z = 1'b0;
         armed = 1'b1;
      end else begin
         push = in_valid && m_q.size() < DEPTH;
         pop  = m_q.size() > 0 && (!m_v || out_ready);
         if (pop) begin
            h = m_q.pop_front();
            m_d = shf(h.d, h.n, h.c);
            m_z = m_d == 8'h00;
            m_v = 1'b1;
         end else if (m_v && out_ready) m_v = 1'b0;
         if (push) begin
            m_q.push_back('{in_data, in_num, in_ctl});
            nacc++;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
         chk("out_valid", 32'(out_valid), 32'(m_v));
         chk("out_data", 32'(out_data), 32'(m_d));
         chk("out_zero", 32'(out_zero), 32'(m_z));
         chk("shift_in", 32'(shift_in), m_q.size() ? 32'(m_q[0].d) : 0);
         chk("shift_num", 32'(shift_num), m_q.size() ? 32'(m_q[0].n) : 0);
         chk("shift_ctl", 32'(shift_ctl), m_q.size() ? 32'(m_q[0].c) : 0);
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] d, input logic [2:0] n, input logic [1:0] c);
      in_valid = 1'b1;
      in_data  = d;
      in_num   = n;
      in_ctl   = c;
   endtask

   task automatic single(input logic [7:0] d, input logic [2:0] n, input logic [1:0] c,
                         input logic [7:0] exp, input logic ez, input string nm);
      drive(d, n, c);
      cyc();
      in_valid = 1'b0;
      cyc();
      chk({nm, "_valid"}, 32'(out_valid), 1);
      chk({nm, "_data"}, 32'(out_data), 32'(exp));
      chk({nm, "_zero"}, 32'(out_zero), 32'(ez));
   endtask

   initial begin
      logic [7:0] got[$];
      int bub, a0, r0, target;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      single(8'h96, 3'd3, 2'b00, 8'hB0, 1'b0, "sll");
      single(8'h96, 3'd2, 2'b01, 8'h25, 1'b0, "srl");
      single(8'h96, 3'd1, 2'b10, 8'hCB, 1'b0, "sra");
      single(8'h96, 3'd4, 2'b11, 8'h69, 1'b0, "ror");
      single(8'h80, 3'd1, 2'b00, 8'h00, 1'b1, "zero1");
      single(8'h01, 3'd0, 2'b00, 8'h01, 1'b0, "zero0");
      cyc();
      // Backpressure: one result parked in the slot, four commands fill the FIFO.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(8'h01, 3'(i), 2'b00);
         cyc();
      end
      chk("bp_full", 32'(in_ready), 0);
      drive(8'hFF, 3'd0, 2'b00);
      cyc();
      chk("bp_refused", 32'(in_ready), 0);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_stable", 32'(out_data), 32'h01);
         cyc();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) got.push_back(out_data);
         cyc();
      end
      chk("bp_count", 32'(got.size()), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_order", 32'(got[i]), 32'(8'h01 << i));
      chk("bp_drained", 32'(out_valid), 0);
      // Streaming with both sides always ready: one result per cycle.
      bub = 0;
      for (int i = 0; i < 300; i++) begin
         drive(8'(i * 37), 3'(i), 2'(i >> 3));
         if (i >= 2 && !out_valid) bub++;
         cyc();
      end
      in_valid = 1'b0;
      chk("stream_bubbles", 32'(bub), 0);
      repeat (4) cyc();
      a0 = nacc;
      r0 = dres;
      target = nacc + 1000;
      for (int k = 0; k < 20000 && nacc < target; k++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         in_num    = 3'($urandom);
         in_ctl    = 2'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) cyc();
      chk("rand_accepted", 32'(nacc - a0), 1000);
      chk("rand_delivered", 32'(dres - r0), 32'(nacc - a0));
      // Flush with a held result and three queued commands.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(8'hA0 + 8'(i), 3'd1, 2'b01);
         cyc();
      end
      drive(8'h77, 3'd0, 2'b00);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      chk("flush_shift_in", 32'(shift_in), 0);
      out_ready = 1'b1;
      drive(8'h96, 3'd4, 2'b11);
      cyc();
      in_valid = 1'b0;
      chk("flush_head", 32'(shift_in), 32'h96);
      cyc();
      chk("flush_data", 32'(out_data), 32'h69);
      chk("flush_valid", 32'(out_valid), 1);
      cyc();
      // Reset while full with a same-cycle push.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(8'h10 + 8'(i), 3'd0, 2'b00);
         cyc();
      end
      chk("rstmid_full", 32'(in_ready), 0);
      drive(8'h55, 3'd0, 2'b00);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("rstmid_valid", 32'(out_valid), 0);
      chk("rstmid_ready", 32'(in_ready), 1);
      chk("rstmid_data", 32'(out_data), 0);
      cyc();
      chk("rstmid_nopush", 32'(out_valid), 0);
      chk("rstmid_empty", 32'(shift_in), 0);
      single(8'h3C, 3'd2, 2'b10, 8'h0F, 1'b0, "rstmid_next");
      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
